// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer defaults, fill FSM states and the shared (x,y) -> address helper
package fb_pkg;
  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_ADDR_W = 19;

  typedef enum logic [1:0] {IDLE, WAIT_VBL, RUN, DONE} fill_state_t;

  // hres is a constant at every call site, so the multiply reduces to shift-add
  function automatic logic [DEF_ADDR_W-1:0] xy_to_addr(input logic [9:0] x, input logic [8:0] y,
                                                        input int hres = DEF_H_RES);
    return DEF_ADDR_W'(y) * DEF_ADDR_W'(hres) + DEF_ADDR_W'(x);
  endfunction
endpackage

// File: rtl/fb_fill_engine.sv
// fb_fill_engine: clipped rectangle fill, one pixel request per granted cycle; FB_FILL_VBLANK_EN holds the first write until vblank
module fb_fill_engine
  import fb_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  input  logic              color,
  input  logic              vblank,
  input  logic              grant,
  output logic              req,
  output logic [ADDR_W-1:0] addr,
  output logic              data,
  output logic              busy,
  output logic              done
);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [9:0]  VR = 10'(V_RES);

  fill_state_t       state, nxt;
  logic [10:0]       col, x_lo, x_end, x_sum;
  logic [9:0]        row, y_end, y_sum;
  logic [ADDR_W-1:0] row_base;
  logic              empty, zero, last_col, last_row;

  assign x_sum    = {1'b0, x0} + {1'b0, w};
  assign y_sum    = {1'b0, y0} + {1'b0, h};
  assign zero     = w == '0 || h == '0 || {1'b0, x0} >= HR || {1'b0, y0} >= VR;
  assign last_col = col + 11'd1 == x_end;
  assign last_row = row + 10'd1 == y_end;
  assign req      = state == RUN && !empty;
  assign addr     = row_base + ADDR_W'(col);
  assign busy     = state == WAIT_VBL || state == RUN;
  assign done     = state == DONE;

`ifndef FB_FILL_VBLANK_EN
  logic unused_vblank;
  assign unused_vblank = vblank;
`endif

  // next state; an empty rectangle spends a single request-free RUN cycle before DONE
  always_comb begin
    nxt = state;
    case (state)
`ifdef FB_FILL_VBLANK_EN
      IDLE:     if (start) nxt = zero ? RUN : WAIT_VBL;
      WAIT_VBL: if (vblank) nxt = RUN;
`else
      IDLE:     if (start) nxt = RUN;
`endif
      RUN:      if (empty || (grant && last_col && last_row)) nxt = DONE;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // state register, clipped rectangle latch and raster counters (row base stepped by addition)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      empty <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) begin
        x_lo     <= {1'b0, x0};
        col      <= {1'b0, x0};
        row      <= {1'b0, y0};
        x_end    <= x_sum > HR ? HR : x_sum;
        y_end    <= y_sum > VR ? VR : y_sum;
        row_base <= ADDR_W'(xy_to_addr(10'd0, y0, H_RES));
        data     <= color;
        empty    <= zero;
      end else if (grant) begin
        col <= last_col ? x_lo : col + 11'd1;
        if (last_col) begin
          row      <= row + 10'd1;
          row_base <= row_base + ADDR_W'(H_RES);
        end
      end
    end
  end
endmodule

// File: rtl/fb_write_sched.sv
// fb_write_sched: round-robin arbiter of CPU pixel writes and the fill engine onto a registered RAM write port (FB_FILL_VBLANK_EN: tear-free fill start)
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int H_RES  = DEF_H_RES,
  parameter int V_RES  = DEF_V_RES,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [9:0]        cpu_x,
  input  logic [8:0]        cpu_y,
  input  logic              cpu_data,
  input  logic              fill_start,
  input  logic [9:0]        fill_x0,
  input  logic [8:0]        fill_y0,
  input  logic [9:0]        fill_w,
  input  logic [8:0]        fill_h,
  input  logic              fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              vblank,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic              fb_wdata
);
  localparam logic [10:0] HR = 11'(H_RES);
  localparam logic [9:0]  VR = 10'(V_RES);

  logic              fill_req, fill_color_q, gnt_fill, gnt_cpu, last_cpu, cpu_in;
  logic [ADDR_W-1:0] fill_addr, cpu_addr;

  fb_fill_engine #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W)) u_fill (
    .clk(clk), .rst_n(rst_n), .start(fill_start),
    .x0(fill_x0), .y0(fill_y0), .w(fill_w), .h(fill_h), .color(fill_color),
    .vblank(vblank), .grant(gnt_fill), .req(fill_req), .addr(fill_addr),
    .data(fill_color_q), .busy(fill_busy), .done(fill_done)
  );

  assign cpu_addr  = ADDR_W'(xy_to_addr(cpu_x, cpu_y, H_RES));
  assign cpu_in    = {1'b0, cpu_x} < HR && {1'b0, cpu_y} < VR;
  assign gnt_fill  = fill_req && (!cpu_valid || last_cpu);
  assign gnt_cpu   = rst_n && cpu_valid && !gnt_fill;
  assign cpu_ready = gnt_cpu;

  // round-robin pointer and the registered write port; off-screen CPU writes are acknowledged but not written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_cpu <= 1'b0;
      fb_we    <= 1'b0;
      fb_waddr <= '0;
      fb_wdata <= 1'b0;
    end else begin
      if (gnt_cpu || gnt_fill) begin
        last_cpu <= gnt_cpu;
        fb_waddr <= gnt_fill ? fill_addr : cpu_addr;
        fb_wdata <= gnt_fill ? fill_color_q : cpu_data;
      end
      fb_we <= gnt_fill || (gnt_cpu && cpu_in);
    end
  end
endmodule

// File: tb/tb_fb_write_sched.sv
// tb_fb_write_sched: randomized scoreboard bench for fb_write_sched against a pixel-list reference model
module tb_fb_write_sched;
  logic        clk = 0, rst_n = 0, cpu_valid = 0, cpu_data = 0, fill_start = 0, fill_color = 0, vblank = 0;
  logic [9:0]  cpu_x = 0, fill_x0 = 0, fill_w = 0;
  logic [8:0]  cpu_y = 0, fill_y0 = 0, fill_h = 0;
  logic        cpu_ready, fill_busy, fill_done, fb_we, fb_wdata;
  logic [18:0] fb_waddr;

  typedef struct {int addr; bit data; int due;} wr_t;
  wr_t exp_q[$];
  int  fill_q[$];
  bit  fcolor, last_cpu, mon_en;
  int  phase, cyc, n_cmp, n_bad, fill_writes;

  fb_write_sched dut (
    .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
    .cpu_x(cpu_x), .cpu_y(cpu_y), .cpu_data(cpu_data),
    .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_w(fill_w), .fill_h(fill_h),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done), .vblank(vblank),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: every cycle the write port must match the scoreboard entry due now, or be idle
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        chk("fb_we", fb_we, 1);
        chk("fb_waddr", fb_waddr, exp_q[0].addr);
        chk("fb_wdata", fb_wdata, exp_q[0].data);
        void'(exp_q.pop_front());
      end else chk("fb_we idle", fb_we, 0);
    end
  end

  // one cycle: check combinational outputs against the model, then advance the model across the edge
  task automatic tick();
    bit gf, gc;
    int xe, ye;
    #1;
    chk("fill_busy", fill_busy, phase == 1);
    chk("fill_done", fill_done, phase == 2);
    gf = rst_n && phase == 1 && fill_q.size() > 0 && (!cpu_valid || last_cpu);
    gc = rst_n && cpu_valid && !gf;
    chk("cpu_ready", cpu_ready, gc);
    if (!rst_n) begin
      phase = 0;
      fill_q.delete();
      last_cpu = 0;
    end else begin
      if (gc && cpu_x < 640 && cpu_y < 480) exp_q.push_back('{int'(cpu_y) * 640 + int'(cpu_x), cpu_data, cyc + 1});
      if (gf) begin
        exp_q.push_back('{fill_q.pop_front(), fcolor, cyc + 1});
        fill_writes++;
      end
      if (gc || gf) last_cpu = gc;
      if (phase == 0 && fill_start) begin
        xe = int'(fill_x0) + int'(fill_w) > 640 ? 640 : int'(fill_x0) + int'(fill_w);
        ye = int'(fill_y0) + int'(fill_h) > 480 ? 480 : int'(fill_y0) + int'(fill_h);
        for (int y = int'(fill_y0); y < ye; y++)
          for (int x = int'(fill_x0); x < xe; x++) fill_q.push_back(y * 640 + x);
        fcolor = fill_color;
        phase  = 1;
      end else if (phase == 1) begin
        if (fill_q.size() == 0) phase = 2;
      end else phase = 0;
    end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (phase != 0 && n < 20000) begin
      tick();
      n++;
    end
    if (phase != 0) chk("fill timeout", phase, 0);
    repeat (2) tick();
  endtask

  task automatic cpu_wr(int x, int y, bit d);
    cpu_valid = 1;
    cpu_x     = 10'(x);
    cpu_y     = 9'(y);
    cpu_data  = d;
    tick();
    cpu_valid = 0;
  endtask

  task automatic start_fill(int x0, int y0, int w, int h, bit c);
    fill_x0    = 10'(x0);
    fill_y0    = 9'(y0);
    fill_w     = 10'(w);
    fill_h     = 9'(h);
    fill_color = c;
    fill_start = 1;
    tick();
    fill_start = 0;
  endtask

  initial begin
    cpu_valid = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst fb_we", fb_we, 0);
    chk("rst fb_waddr", fb_waddr, 0);
    chk("rst fb_wdata", fb_wdata, 0);
    chk("rst fill_busy", fill_busy, 0);
    chk("rst fill_done", fill_done, 0);
    chk("rst cpu_ready", cpu_ready, 0);
    @(negedge clk);
    cpu_valid = 0;
    rst_n     = 1;
    mon_en    = 1;
    cpu_wr(639, 479, 1);
    cpu_wr(640, 0, 1);
    cpu_wr(0, 480, 0);
    cpu_wr(7, 3, 1);
    tick();
    start_fill(10, 2, 3, 2, 1);
    wait_idle();
    start_fill(638, 479, 10, 10, 1);
    wait_idle();
    start_fill(5, 5, 0, 4, 1);
    wait_idle();
    start_fill(700, 0, 5, 5, 1);
    wait_idle();
    cpu_valid = 1;
    cpu_x     = 100;
    cpu_y     = 1;
    cpu_data  = 1;
    tick();
    start_fill(20, 0, 4, 1, 0);
    wait_idle();
    cpu_valid = 0;
    start_fill(0, 10, 20, 1, 1);
    repeat (3) tick();
    start_fill(300, 300, 9, 9, 0);
    wait_idle();
    fill_writes = 0;
    start_fill(0, 0, 100, 100, 1);
    for (int n = 0; n < 1000 && fill_writes < 50; n++) tick();
    chk("mid-fill writes", fill_writes, 50);
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("post-rst fb_waddr", fb_waddr, 0);
    repeat (20) tick();
    repeat (3000) begin
      cpu_valid  = 1'($urandom_range(0, 1));
      cpu_x      = 10'($urandom_range(0, 700));
      cpu_y      = 9'($urandom_range(0, 500));
      cpu_data   = 1'($urandom);
      vblank     = 1'($urandom);
      fill_start = $urandom_range(0, 15) == 0;
      fill_x0    = 10'($urandom_range(0, 650));
      fill_y0    = 9'($urandom_range(0, 485));
      fill_w     = 10'($urandom_range(0, 3) == 0 ? $urandom_range(0, 1023) : $urandom_range(0, 12));
      fill_h     = 9'($urandom_range(0, 4));
      fill_color = 1'($urandom);
      tick();
    end
    cpu_valid  = 0;
    fill_start = 0;
    wait_idle();
    chk("pending writes", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fb_write_sched.md
Name: fb_write_sched

Overview:
- Write-port controller for the 640x480 1-bpp frame buffer RAM.
- Arbitrates between two sources: single-pixel CPU writes (valid/ready) and a built-in rectangle fill engine used for clear, background and box drawing.
- Converts (x,y) to a linear address and drives the RAM write port through registered outputs.
- Sits between the VGA peripheral's register interface and the RAM; the RAM read/video path is untouched.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- ADDR_W, 19, RAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cpu_valid  in  1  CPU pixel write request
- cpu_ready  out  1  CPU request accepted this cycle
- cpu_x  in  10  pixel column
- cpu_y  in  9  pixel row
- cpu_data  in  1  pixel value
- fill_start  in  1  one-cycle pulse; latches the rectangle
- fill_x0  in  10  rectangle left edge
- fill_y0  in  9  rectangle top edge
- fill_w  in  10  rectangle width
- fill_h  in  9  rectangle height
- fill_color  in  1  fill value
- fill_busy  out  1  fill engine active
- fill_done  out  1  one-cycle completion pulse
- vblank  in  1  vertical blank level from the timing generator
- fb_we  out  1  RAM write enable
- fb_waddr  out  ADDR_W  RAM write address
- fb_wdata  out  1  RAM write data

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - fb_we, fb_waddr, fb_wdata, fill_busy, fill_done, cpu_ready all 0.
  - FSM goes to IDLE; round-robin pointer is set to CPU-first.
  - A fill in progress is abandoned with no fill_done.
- FSM states:
  - IDLE -> RUN on fill_start (with FB_FILL_VBLANK_EN: IDLE -> WAIT_VBL).
  - WAIT_VBL -> RUN on vblank=1.
  - RUN -> DONE after the last pixel is issued.
  - DONE -> IDLE after one cycle; fill_done=1 only in DONE.
  - fill_busy=1 in WAIT_VBL and RUN.
- fill_start outside IDLE is ignored; the latched parameters stay unchanged.
- Clipping is applied at latch time:
  - x_end = min(x0+w, H_RES); y_end = min(y0+h, V_RES).
  - If w=0, h=0, x0>=H_RES or y0>=V_RES, the engine goes directly to DONE: zero writes, fill_busy high for exactly one cycle (the start cycle is not counted; the DONE cycle follows immediately).
- Fill scan order: raster order, column fastest.
  - A row-base register starts at y0*H_RES and adds H_RES per row; the column counter restarts at x0.
  - No multiplier in the fill loop.
- CPU address is cpu_y*H_RES+cpu_x as a constant multiply (shift-add), ADDR_W bits.
- Arbitration, per cycle:
  - The fill engine requests when in RUN.
  - If only one source requests, it wins.
  - If both request, round-robin: the source not granted last time wins, then the pointer flips.
  - Worst-case wait for either source is 1 cycle.
- cpu_ready is combinational: cpu_valid AND CPU granted.
- An accepted CPU write with cpu_x>=H_RES or cpu_y>=V_RES is dropped: handshake completes, fb_we stays 0.
- Latency: the grant cycle's write appears on fb_we/fb_waddr/fb_wdata at the next clk edge, registered. fb_we=0 on cycles with no grant.
- Throughput: one pixel per cycle total. A w x h fill with no CPU traffic takes w*h RUN cycles.
- CPU and fill writes to the same pixel in adjacent cycles: the RAM applies them in grant order, so the last grant wins.

Optional Feature:
- Macro: FB_FILL_VBLANK_EN.
- Defined: fill_start enters WAIT_VBL and the engine waits until vblank=1 before the first write (tear-free clears). Once RUN starts, vblank falling does not pause the fill.
- Undefined: no WAIT_VBL state; the vblank port is ignored; RUN is entered the cycle after fill_start.

Decomposition:
- Package fb_pkg holds:
  - H_RES/V_RES defaults
  - ADDR_W
  - the state enum fill_state_t {IDLE, WAIT_VBL, RUN, DONE}
  - an xy_to_addr constant-multiply function, shared with the read-side address generator
- One sub-module, fb_fill_engine: FSM, clipping, counters and request output. The top level holds the arbiter and the output registers.

Test Plan:
- Reset mid-fill: start a 100x100 fill, assert rst_n=0 after 50 writes -> next cycle fb_we=0, fill_busy=0; no fill_done ever.
- CPU only: write (639,479)=1 -> one cycle later fb_we=1, fb_waddr=307199, fb_wdata=1. Write (640,0) -> cpu_ready=1, no fb_we.
- Fill: x0=10, y0=2, w=3, h=2, color=1 -> exactly 6 writes to addresses 1290,1291,1292,1930,1931,1932, then fill_done one cycle later.
- Clipping: x0=638, y0=479, w=10, h=10 -> 2 writes (307198, 307199). Separately, w=0 -> no writes, fill_done pulse, fill_busy high one cycle.
- Contention: cpu_valid held high during a 4x1 fill -> grants alternate (fill, CPU, fill, CPU, ...); fill finishes in 8 cycles; no source waits more than 1 cycle.
- FB_FILL_VBLANK_EN: fill_start with vblank=0 for 20 cycles -> no fill writes, fill_busy=1. vblank=1 -> first write on the following cycle.
